// File: rtl/traffic_light_fsm.sv
// Tick-driven two-way traffic-light controller: each flip edge is one tick, timed Moore FSM
// drives one-hot lamps. Optional pedestrian phase is built only when PED_PHASE_EN is defined.
module traffic_light_fsm #(
    parameter int unsigned GREEN_TICKS  = 8,
    parameter int unsigned YELLOW_TICKS = 3,
    parameter int unsigned RED_TICKS    = 1,
    parameter int unsigned WALK_TICKS   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flip,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_NS_G  = 3'd0,
        ST_NS_Y  = 3'd1,
        ST_RED_A = 3'd2,
        ST_EW_G  = 3'd3,
        ST_EW_Y  = 3'd4,
        ST_RED_B = 3'd5,
        ST_WALK  = 3'd6,
        ST_BAD   = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Counter compares against dwell-1 so a state lasts exactly its dwell in ticks.
    localparam logic [7:0] GREEN_LAST  = 8'(GREEN_TICKS - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TICKS - 1);
    localparam logic [7:0] RED_LAST    = 8'(RED_TICKS - 1);
    localparam logic [7:0] WALK_LAST   = 8'(WALK_TICKS - 1);

    state_t     state_q, state_d;
    state_t     succ;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] dwell_last;
    logic       flip_q;
    logic       tick;
    logic       legal;
    logic       ped_pending_q;
    logic       walk_from_a_q;

    assign tick = flip ^ flip_q;

`ifdef PED_PHASE_EN
    logic ped_pending_d;
    logic walk_from_a_d;
    logic enter_walk;
`else
    logic       ped_req_unused;
    logic [7:0] walk_last_unused;
    assign ped_req_unused   = ped_req;
    assign walk_last_unused = WALK_LAST;
    assign ped_pending_q    = 1'b0;
    assign walk_from_a_q    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_NS_G;
            cnt_q   <= 8'd0;
            flip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flip_q  <= flip;
        end
    end

    always_comb begin
        succ       = ST_NS_G;
        dwell_last = GREEN_LAST;
        legal      = 1'b1;
        case (state_q)
            ST_NS_G: begin
                dwell_last = GREEN_LAST;
                succ       = ST_NS_Y;
            end
            ST_NS_Y: begin
                dwell_last = YELLOW_LAST;
                succ       = ST_RED_A;
            end
            ST_RED_A: begin
                dwell_last = RED_LAST;
                succ       = ped_pending_q ? ST_WALK : ST_EW_G;
            end
            ST_EW_G: begin
                dwell_last = GREEN_LAST;
                succ       = ST_EW_Y;
            end
            ST_EW_Y: begin
                dwell_last = YELLOW_LAST;
                succ       = ST_RED_B;
            end
            ST_RED_B: begin
                dwell_last = RED_LAST;
                succ       = ped_pending_q ? ST_WALK : ST_NS_G;
            end
`ifdef PED_PHASE_EN
            ST_WALK: begin
                dwell_last = WALK_LAST;
                succ       = walk_from_a_q ? ST_EW_G : ST_NS_G;
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    // Unreachable encodings fall back to NS_G on the next clock, ticks or not.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!legal) begin
            state_d = ST_NS_G;
            cnt_d   = 8'd0;
        end else if (tick) begin
            if (cnt_q == dwell_last) begin
                state_d = succ;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

`ifdef PED_PHASE_EN
    assign enter_walk = (state_d == ST_WALK) && (state_q != ST_WALK);

    // Entering WALK services the request, so the clear beats a same-cycle set.
    always_comb begin
        ped_pending_d = ped_pending_q;
        walk_from_a_d = walk_from_a_q;
        if (enter_walk) begin
            ped_pending_d = 1'b0;
            walk_from_a_d = (state_q == ST_RED_A);
        end else if (ped_req && (state_q != ST_WALK)) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_pending_q <= 1'b0;
            walk_from_a_q <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            walk_from_a_q <= walk_from_a_d;
        end
    end

    assign walk = (state_q == ST_WALK);
`else
    assign walk = 1'b0;
`endif

    // Illegal encodings show all-red so the safety invariant holds even then.
    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state_q)
            ST_NS_G: ns_light = LAMP_GREEN;
            ST_NS_Y: ns_light = LAMP_YELLOW;
            ST_EW_G: ew_light = LAMP_GREEN;
            ST_EW_Y: ew_light = LAMP_YELLOW;
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomized and directed bench for traffic_light_fsm against a ring-of-phases reference model.
// Works with or without PED_PHASE_EN defined, matching the build of the design.
module tb_traffic_light_fsm;

    localparam int G = 4;
    localparam int Y = 2;
    localparam int R = 1;
    localparam int W = 3;
`ifdef PED_PHASE_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       flip;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [2:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: position on the six-phase ring plus a walk interlude flag.
    int   m_pos;
    int   m_left;
    bit   m_walk;
    bit   m_ped;
    bit   m_fprev;
    logic tb_flip;

    always #5 clk = ~clk;

    traffic_light_fsm #(
        .GREEN_TICKS (G),
        .YELLOW_TICKS(Y),
        .RED_TICKS   (R),
        .WALK_TICKS  (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flip     (flip),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .state_dbg(state_dbg)
    );

    task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int dwell_now();
        if (m_walk) return W;
        case (m_pos % 3)
            0:       return G;
            1:       return Y;
            default: return R;
        endcase
    endfunction

    task automatic model_reset();
        m_pos   = 0;
        m_walk  = 1'b0;
        m_left  = G;
        m_ped   = 1'b0;
        m_fprev = 1'b0;
    endtask

    task automatic model_step(input logic f, input logic pr);
        bit is_tick;
        bit was_walk;
        bit old_ped;
        bit entering;
        is_tick  = (f != m_fprev);
        m_fprev  = f;
        was_walk = m_walk;
        old_ped  = m_ped;
        entering = 1'b0;
        if (is_tick) begin
            m_left--;
            if (m_left == 0) begin
                if (!m_walk && (m_pos % 3 == 2) && old_ped) begin
                    m_walk   = 1'b1;
                    entering = 1'b1;
                end else begin
                    m_walk = 1'b0;
                    m_pos  = (m_pos + 1) % 6;
                end
                m_left = dwell_now();
            end
        end
        if (PED) begin
            if (entering) m_ped = 1'b0;
            else if (pr && !was_walk) m_ped = 1'b1;
        end
    endtask

    task automatic check_outputs(input string where);
        logic [2:0] e_ns;
        logic [2:0] e_ew;
        logic [2:0] e_st;
        e_ns = 3'b100;
        e_ew = 3'b100;
        e_st = m_walk ? 3'd6 : 3'(m_pos);
        if (!m_walk) begin
            if (m_pos == 0) e_ns = 3'b001;
            if (m_pos == 1) e_ns = 3'b010;
            if (m_pos == 3) e_ew = 3'b001;
            if (m_pos == 4) e_ew = 3'b010;
        end
        check_value({where, ".ns"}, 8'(ns_light), 8'(e_ns));
        check_value({where, ".ew"}, 8'(ew_light), 8'(e_ew));
        check_value({where, ".walk"}, 8'(walk), 8'(m_walk));
        check_value({where, ".state"}, 8'(state_dbg), 8'(e_st));
        check_value({where, ".safety"}, 8'((ns_light[1:0] != 2'b00) && (ew_light[1:0] != 2'b00)), 8'd0);
    endtask

    task automatic step(input logic f, input logic pr, input logic rst);
        @(negedge clk);
        flip    = f;
        ped_req = pr;
        reset   = rst;
        if (!rst) begin
            #1;
            model_reset();
            check_outputs("async_rst");
        end
        @(posedge clk);
        if (rst) model_step(f, pr);
        else model_reset();
        #1;
        check_outputs("cycle");
    endtask

    task automatic tick_gap(input int n, input logic pr);
        for (int i = 0; i < n; i++) begin
            tb_flip = ~tb_flip;
            for (int c = 0; c < 10; c++) step(tb_flip, pr, 1'b1);
        end
    endtask

    task automatic do_reset(input int n);
        tb_flip = 1'b0;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset   = 1'b0;
        flip    = 1'b0;
        ped_req = 1'b0;
        tb_flip = 1'b0;
        model_reset();

        // Reset held while flip toggles: lamps must stay at NS_G.
        for (int i = 0; i < 5; i++) begin
            tb_flip = ~tb_flip;
            step(tb_flip, 1'b0, 1'b0);
        end
        // flip is 1 at release, so the first cycle counts as a tick.
        step(tb_flip, 1'b0, 1'b1);
        tick_gap(15, 1'b0);

        // Single-cycle pedestrian pulse during NS_G tick 2, then plain laps.
        do_reset(2);
        tick_gap(1, 1'b0);
        tb_flip = ~tb_flip;
        step(tb_flip, 1'b0, 1'b1);
        step(tb_flip, 1'b0, 1'b1);
        step(tb_flip, 1'b1, 1'b1);
        for (int c = 0; c < 7; c++) step(tb_flip, 1'b0, 1'b1);
        tick_gap(30, 1'b0);

        // Request held high throughout.
        do_reset(2);
        tick_gap(40, 1'b1);

        // Pending request dropped by reset mid-EW_G.
        do_reset(2);
        tick_gap(7, 1'b0);
        tb_flip = ~tb_flip;
        step(tb_flip, 1'b0, 1'b1);
        step(tb_flip, 1'b1, 1'b1);
        for (int c = 0; c < 8; c++) step(tb_flip, 1'b0, 1'b1);
        tb_flip = ~tb_flip;
        for (int c = 0; c < 3; c++) step(tb_flip, 1'b0, 1'b1);
        do_reset(2);
        tick_gap(15, 1'b0);

        // One tick per cycle.
        for (int i = 0; i < 60; i++) begin
            tb_flip = ~tb_flip;
            step(tb_flip, 1'($urandom_range(0, 1)), 1'b1);
        end

        // Random flip, request and reset traffic.
        for (int i = 0; i < 3000; i++) begin
            logic pr;
            logic rst;
            if ($urandom_range(0, 2) == 0) tb_flip = ~tb_flip;
            pr  = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 199) != 0);
            step(tb_flip, pr, rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
